// File: rtl/sound_sequencer_if.sv
// rtl/sound_sequencer_if.sv - game-logic event bus for the sound sequencer
// Carries the event strobe towards the sequencer and its queue status back.
interface sound_sequencer_if #(
  parameter int M      = 2,
  parameter int QDEPTH = 4
) ();

  logic [M-1:0]                  sound_event_code_in;
  logic                          sound_trigger_in;
  logic                          busy;
  logic [$clog2(QDEPTH+1)-1:0]   queue_count;
  logic                          dropped;

  modport master (
    output sound_event_code_in,
    output sound_trigger_in,
    input  busy,
    input  queue_count,
    input  dropped
  );

  modport slave (
    input  sound_event_code_in,
    input  sound_trigger_in,
    output busy,
    output queue_count,
    output dropped
  );

endinterface

// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - queued multi-note square-wave buzzer engine
// Events are queued and played as short melodies; GAME_OVER preempts and flushes the queue.
module sound_sequencer #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int          M        = 2,
  parameter int          QDEPTH   = 4,
  parameter int          GAP_MS   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mute_in,
  output logic               buzzer_out,
  sound_sequencer_if.slave   bus
);

  localparam int unsigned MS_CYC = CLK_FREQ / 1000;
  localparam int          QW     = $clog2(QDEPTH + 1);
  localparam int          PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  localparam logic [1:0] EV_EAT   = 2'd1;
  localparam logic [1:0] EV_GO    = 2'd2;
  localparam logic [1:0] EV_START = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_t;

  function automatic logic [31:0] f_half(input logic [1:0] evt, input logic [1:0] idx);
    logic [31:0] h;
    h = 32'd1;
    case ({evt, idx})
      {EV_EAT,   2'd0}: h = 32'(CLK_FREQ / (2 * 2000));
      {EV_EAT,   2'd1}: h = 32'(CLK_FREQ / (2 * 2500));
      {EV_START, 2'd0}: h = 32'(CLK_FREQ / (2 * 1000));
      {EV_START, 2'd1}: h = 32'(CLK_FREQ / (2 * 1500));
      {EV_START, 2'd2}: h = 32'(CLK_FREQ / (2 * 2000));
      {EV_GO,    2'd0}: h = 32'(CLK_FREQ / (2 * 800));
      {EV_GO,    2'd1}: h = 32'(CLK_FREQ / (2 * 600));
      {EV_GO,    2'd2}: h = 32'(CLK_FREQ / (2 * 400));
      {EV_GO,    2'd3}: h = 32'(CLK_FREQ / (2 * 300));
      default:          h = 32'd1;
    endcase
    return h;
  endfunction

  function automatic logic [15:0] f_dur_ms(input logic [1:0] evt, input logic [1:0] idx);
    logic [15:0] d;
    d = 16'd1;
    case ({evt, idx})
      {EV_EAT,   2'd0}: d = 16'd30;
      {EV_EAT,   2'd1}: d = 16'd20;
      {EV_START, 2'd0},
      {EV_START, 2'd1},
      {EV_START, 2'd2}: d = 16'd50;
      {EV_GO,    2'd0},
      {EV_GO,    2'd1}: d = 16'd150;
      {EV_GO,    2'd2}: d = 16'd200;
      {EV_GO,    2'd3}: d = 16'd300;
      default:          d = 16'd1;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] f_last_idx(input logic [1:0] evt);
    case (evt)
      EV_EAT:   return 2'd1;
      EV_START: return 2'd2;
      EV_GO:    return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_fifo [QDEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [QW-1:0] r_count;
  logic          r_dropped;
  logic [1:0]    r_event, r_idx;
  logic [31:0]   r_half, r_pwm, r_pre;
  logic [15:0]   r_ms;
  logic          r_wave, r_buzzer;

  logic [M-1:0]  w_code_raw;
  logic [31:0]   w_code;
  logic          w_go, w_push, w_pop, w_full, w_wr, w_drop;
  logic [1:0]    w_push_evt;
  logic          w_tick, w_expire, w_last, w_wrap;
  logic          w_load, w_gap_start, w_wave_nxt;
  logic [1:0]    w_load_evt, w_load_idx;

  assign w_code_raw = bus.sound_event_code_in;
  assign w_code     = 32'(w_code_raw);
  assign w_go       = bus.sound_trigger_in && (w_code == 32'd2);
  assign w_push     = bus.sound_trigger_in && ((w_code == 32'd1) || (w_code == 32'd3));
  assign w_push_evt = (w_code == 32'd1) ? EV_EAT : EV_START;

  // A pop frees a slot in the same cycle, so a push into a full queue is kept then.
  assign w_full = (r_count == QW'(QDEPTH));
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && !w_go;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  assign w_tick   = (r_pre == MS_CYC - 1);
  assign w_expire = w_tick && (r_ms == 16'd1);
  assign w_last   = (r_idx == f_last_idx(r_event));
  assign w_wrap   = (r_pwm == r_half - 32'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_evt  = r_event;
    w_load_idx  = r_idx + 2'd1;
    w_gap_start = 1'b0;
    w_wave_nxt  = r_wave;
    case (r_state)
      S_IDLE: begin
        w_wave_nxt = 1'b0;
        if (w_pop) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_wave_nxt  = 1'b0;
        w_load      = 1'b1;
        w_load_idx  = 2'd0;
        w_state_nxt = S_NOTE;
      end
      S_NOTE: begin
        if (w_wrap) w_wave_nxt = ~r_wave;
        if (w_expire) begin
          w_wave_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end else if (GAP_MS > 0) begin
            w_state_nxt = S_GAP;
            w_gap_start = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_GAP: begin
        w_wave_nxt = 1'b0;
        if (w_expire) begin
          w_state_nxt = S_NOTE;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_go) begin
      w_state_nxt = S_NOTE;
      w_load      = 1'b1;
      w_load_evt  = EV_GO;
      w_load_idx  = 2'd0;
      w_wave_nxt  = 1'b0;
    end
  end

  // Note timebase: PWM half-period counter plus 1 ms prescaler and ms down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event  <= 2'd0;
      r_idx    <= 2'd0;
      r_half   <= 32'd0;
      r_pwm    <= 32'd0;
      r_pre    <= 32'd0;
      r_ms     <= 16'd0;
      r_wave   <= 1'b0;
      r_buzzer <= 1'b0;
    end else begin
      r_wave   <= w_wave_nxt;
      r_buzzer <= w_wave_nxt & ~mute_in;
      if (w_pop) r_event <= r_fifo[r_rd_ptr];
      if (w_load) begin
        r_event <= w_load_evt;
        r_idx   <= w_load_idx;
        r_half  <= f_half(w_load_evt, w_load_idx);
        r_ms    <= f_dur_ms(w_load_evt, w_load_idx);
        r_pre   <= 32'd0;
        r_pwm   <= 32'd0;
      end else if (w_gap_start) begin
        r_ms  <= 16'(GAP_MS);
        r_pre <= 32'd0;
        r_pwm <= 32'd0;
      end else if ((r_state == S_NOTE) || (r_state == S_GAP)) begin
        r_pwm <= w_wrap ? 32'd0 : r_pwm + 32'd1;
        if (w_tick) begin
          r_pre <= 32'd0;
          r_ms  <= r_ms - 16'd1;
        end else begin
          r_pre <= r_pre + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_fifo[r_wr_ptr] <= w_push_evt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else if (w_go) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= w_drop;
      if (w_wr)  r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + QW'(1);
        2'b01:   r_count <= r_count - QW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign buzzer_out      = r_buzzer;
  assign bus.busy        = (r_state != S_IDLE) || (r_count != '0);
  assign bus.queue_count = r_count;
  assign bus.dropped     = r_dropped;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - self-checking bench for sound_sequencer
// Melody timeline model with an event queue, directed vector table and random triggers.
module tb_sound_sequencer;

  localparam int unsigned CLK_FREQ = 20_000;
  localparam int MSC    = 20;
  localparam int QDEPTH = 4;
  localparam int GAP_MS = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mute = 1'b0;
  logic       trig = 1'b0;
  logic [1:0] code = 2'd0;
  logic       buzzer;

  sound_sequencer_if #(.M(2), .QDEPTH(QDEPTH)) bus ();

  assign bus.sound_event_code_in = code;
  assign bus.sound_trigger_in    = trig;

  sound_sequencer #(
    .CLK_FREQ(CLK_FREQ), .M(2), .QDEPTH(QDEPTH), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mute_in(mute), .buzzer_out(buzzer), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pending queue plus the melody being played, described by start cycle.
  int q[$];
  int m_mode;   // 0 idle, 1 popped/awaiting note start, 2 playing
  int m_evt;
  int m_t0;
  int n = 0;
  bit e_buz, e_drop;

  function automatic int freq_of(input int evt, input int i);
    case (evt)
      1: return (i == 0) ? 2000 : 2500;
      3: return (i == 0) ? 1000 : (i == 1) ? 1500 : 2000;
      default: return (i == 0) ? 800 : (i == 1) ? 600 : (i == 2) ? 400 : 300;
    endcase
  endfunction

  function automatic int dur_ms(input int evt, input int i);
    case (evt)
      1: return (i == 0) ? 30 : 20;
      3: return 50;
      default: return (i < 2) ? 150 : (i == 2) ? 200 : 300;
    endcase
  endfunction

  function automatic int n_notes(input int evt);
    return (evt == 1) ? 2 : (evt == 3) ? 3 : 4;
  endfunction

  function automatic int melody_len(input int evt);
    int t = 0;
    for (int i = 0; i < n_notes(evt); i++) t += dur_ms(evt, i) * MSC;
    return t + (n_notes(evt) - 1) * GAP_MS * MSC;
  endfunction

  function automatic bit wave_at(input int evt, input int off);
    int o = off;
    for (int i = 0; i < n_notes(evt); i++) begin
      int d = dur_ms(evt, i) * MSC;
      int h = int'(CLK_FREQ) / (2 * freq_of(evt, i));
      if (o < d) return ((o / h) % 2) == 1;
      o -= d;
      if (i < n_notes(evt) - 1) begin
        if (o < GAP_MS * MSC) return 1'b0;
        o -= GAP_MS * MSC;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_evt  = 0;
    e_buz  = 1'b0;
    e_drop = 1'b0;
  endtask

  task automatic model_step();
    bit go, push, pop, drop;
    n++;
    go   = trig && (code == 2'd2);
    push = trig && (code == 2'd1 || code == 2'd3);
    drop = 1'b0;
    if (go) begin
      q.delete();
      m_evt = 2; m_t0 = n; m_mode = 2;
    end else begin
      pop  = (m_mode == 0) && (q.size() > 0);
      drop = push && (q.size() == QDEPTH) && !pop;
      if (pop) begin
        m_evt = q.pop_front(); m_mode = 1;
      end else if (m_mode == 1) begin
        m_mode = 2; m_t0 = n;
      end else if (m_mode == 2 && (n - m_t0) == melody_len(m_evt)) begin
        m_mode = 0;
      end
      if (push && !drop) q.push_back(int'(code));
    end
    e_drop = drop;
    e_buz  = (m_mode == 2) && wave_at(m_evt, n - m_t0) && !mute;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model();
    logic [5:0] act, exp;
    act = {buzzer, bus.busy, bus.queue_count, bus.dropped};
    exp = {e_buz, (m_mode != 0) || (q.size() > 0), 3'(q.size()), e_drop};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model cycle %0d: got buz/busy/cnt/drop=%b/%b/%0d/%b expected %b/%b/%0d/%b",
               n, act[5], act[4], act[3:1], act[0], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
    trig = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] c);
    code = c;
    trig = 1'b1;
    tick();
  endtask

  task automatic run_until_idle(input string nm, input int bound, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.busy && cyc < bound);
    if (bus.busy) check({nm, " idle timeout"}, 1, 0);
  endtask

  task automatic run_until_high(input string nm, input int bound, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!buzzer && cyc < bound);
    if (!buzzer) check({nm, " toggle timeout"}, 0, 1);
  endtask

  typedef struct {
    logic       trig;
    logic [1:0] code;
    int         e_cnt;
    logic       e_busy;
    logic       e_drop;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int c1, c2;
    vecs[0] = '{1'b1, 2'd0, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2'd1, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd3, 1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2'd1, 1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 2, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 2'd1, 3, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 2'd1, 4, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 2'd1, 4, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 2'd1, 4, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 2'd0, 4, 1'b1, 1'b0};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset buzzer", int'(buzzer), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset count", int'(bus.queue_count), 0);
    check("reset dropped", int'(bus.dropped), 0);
    reset_n = 1'b1;

    // Accept rule, fill to full, single-cycle drop pulse
    foreach (vecs[i]) begin
      code = vecs[i].code;
      trig = vecs[i].trig;
      tick();
      check($sformatf("vec%0d count", i), int'(bus.queue_count), vecs[i].e_cnt);
      check($sformatf("vec%0d busy", i), int'(bus.busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d dropped", i), int'(bus.dropped), int'(vecs[i].e_drop));
    end

    // Push on the very cycle IDLE pops the head of a full queue
    c1 = 0;
    while (m_mode != 0 && c1 < 5000) begin
      tick();
      c1++;
    end
    check("start ended in bound", int'(c1 < 5000), 1);
    check("full before collision", int'(bus.queue_count), 4);
    pulse(2'd1);
    check("collision dropped", int'(bus.dropped), 0);
    check("collision count", int'(bus.queue_count), 4);
    run_until_idle("drain", 8000, c1);

    // EAT from idle: note starts 2 cycles after the trigger edge
    pulse(2'd1);
    run_until_high("eat", 100, c1);
    check("eat first toggle", c1, 2 + int'(CLK_FREQ) / (2 * 2000));
    run_until_idle("eat", 3000, c2);
    check("eat busy length", c1 + c2, 2 + (30 + GAP_MS + 20) * MSC);

    // Muted EAT keeps identical busy timing; second run releases mute mid-note
    mute = 1'b1;
    pulse(2'd1);
    run_until_idle("muted eat", 3000, c1);
    check("muted busy length", c1, 2 + (30 + GAP_MS + 20) * MSC);
    pulse(2'd1);
    repeat (303) tick();
    mute = 1'b0;
    run_until_idle("mute release", 3000, c1);

    // GAME_OVER during START note 1 with two EATs waiting
    pulse(2'd3);
    pulse(2'd1);
    pulse(2'd1);
    repeat (1300) tick();
    check("queued before go", int'(bus.queue_count), 2);
    pulse(2'd2);
    check("go flushes queue", int'(bus.queue_count), 0);
    check("go busy", int'(bus.busy), 1);
    check("go buzzer low", int'(buzzer), 0);
    run_until_high("go", 100, c1);
    check("go first toggle", c1, int'(CLK_FREQ) / (2 * 800));
    run_until_idle("go", 20000, c2);
    check("go total length", c1 + c2, (800 + 3 * GAP_MS) * MSC);

    // Asynchronous reset during GAME_OVER note 2 while the buzzer is high
    pulse(2'd2);
    repeat (6300) tick();
    run_until_high("go note2", 200, c1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset buzzer", int'(buzzer), 0);
    check("async reset busy", int'(bus.busy), 0);
    check("async reset count", int'(bus.queue_count), 0);
    check("async reset dropped", int'(bus.dropped), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) tick();
    pulse(2'd0);
    repeat (20) tick();
    check("code0 no activity", int'(bus.busy), 0);

    // Random triggers and mute against the model, one GAME_OVER somewhere in the middle
    c2 = int'($urandom_range(2000, 6000));
    for (int k = 0; k < 8000; k++) begin
      if (k == c2) begin
        code = 2'd2;
        trig = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        c1 = int'($urandom_range(0, 2));
        code = (c1 == 0) ? 2'd0 : (c1 == 1) ? 2'd1 : 2'd3;
        trig = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) mute = ~mute;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
